irq_sequencer: RTL and testbench

- Interrupt controller and PC-redirect sequencer for the single-cycle core.
- Watches retired opcodes for wfi (opcode[4:1]=4'hE) and rfi (opcode[4:1]=4'hF).
- Arbitrates NUM_IRQ level-sensitive request lines and saves and restores the PC.
- Tells the fetch stage when to stall, when to jump to a vector, and when to return.

---
 rtl/irq_sequencer.sv | 132 +++++++++++++
 tb/tb_irq_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_sequencer.sv
// irq_sequencer: fixed-priority interrupt arbiter and PC redirect sequencer for the single-cycle core.
// Optional build macro IRQ_SEQ_WFI_TIMEOUT_EN adds a wfi sleep timeout (parameter WFI_TIMEOUT).
module irq_sequencer #(
    parameter int unsigned NUM_IRQ       = 4,
    parameter int unsigned PC_WIDTH      = 8,
    parameter int unsigned VECTOR_BASE   = 8'hF0,
    parameter int unsigned VECTOR_STRIDE = 4,
    parameter int unsigned ID_WIDTH      = 2
`ifdef IRQ_SEQ_WFI_TIMEOUT_EN
    ,
    parameter int unsigned WFI_TIMEOUT   = 255
`endif
) (
    input  logic                mem_clock,
    input  logic                reset_bar,
    input  logic [4:0]          opcode,
    input  logic                instr_valid,
    input  logic [PC_WIDTH-1:0] pc_current,
    input  logic [NUM_IRQ-1:0]  irq_req,
    input  logic [NUM_IRQ-1:0]  irq_mask,
    output logic                stall,
    output logic                pc_redirect,
    output logic [PC_WIDTH-1:0] pc_target,
    output logic [NUM_IRQ-1:0]  irq_ack,
    output logic                interrupt_active,
    output logic [ID_WIDTH-1:0] active_id,
    output logic [PC_WIDTH-1:0] saved_pc
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SLEEP  = 3'd1;
    localparam logic [2:0] S_ENTER  = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_EXIT   = 3'd4;

    logic [2:0]          state;
    logic [NUM_IRQ-1:0]  pending;
    logic                any_pending;
    logic [ID_WIDTH-1:0] winner;
    logic                is_wfi;
    logic                is_rfi;

    function automatic logic [PC_WIDTH-1:0] vec_addr(input logic [ID_WIDTH-1:0] id);
        logic [31:0] a;
        a = VECTOR_BASE + 32'(id) * VECTOR_STRIDE;
        return a[PC_WIDTH-1:0];
    endfunction

    assign pending     = irq_req & ~irq_mask;
    assign any_pending = |pending;

    // opcode[0] is a don't-care for both system opcodes
    assign is_wfi = (opcode & 5'b11110) == 5'b11100;
    assign is_rfi = (opcode & 5'b11110) == 5'b11110;

    // Scan high to low so the lowest set index is the last write and wins.
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) winner = ID_WIDTH'(i);
        end
    end

`ifdef IRQ_SEQ_WFI_TIMEOUT_EN
    logic [7:0] sleep_cnt;
    logic       sleep_expired;
    assign sleep_expired = ({1'b0, sleep_cnt} + 9'd1) == 9'(WFI_TIMEOUT);
`endif

    always_ff @(posedge mem_clock or negedge reset_bar) begin
        if (!reset_bar) begin
            state     <= S_IDLE;
            saved_pc  <= '0;
            active_id <= '0;
            pc_target <= '0;
`ifdef IRQ_SEQ_WFI_TIMEOUT_EN
            sleep_cnt <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (instr_valid && any_pending) begin
                        saved_pc  <= pc_current;
                        active_id <= winner;
                        pc_target <= vec_addr(winner);
                        state     <= S_ENTER;
                    end else if (instr_valid && is_wfi) begin
                        saved_pc  <= pc_current;
                        state     <= S_SLEEP;
`ifdef IRQ_SEQ_WFI_TIMEOUT_EN
                        sleep_cnt <= '0;
`endif
                    end
                end
                S_SLEEP: begin
                    // saved_pc already points past the wfi
                    if (any_pending) begin
                        active_id <= winner;
                        pc_target <= vec_addr(winner);
                        state     <= S_ENTER;
                    end
`ifdef IRQ_SEQ_WFI_TIMEOUT_EN
                    else if (sleep_expired) begin
                        pc_target <= saved_pc;
                        state     <= S_EXIT;
                    end else begin
                        sleep_cnt <= sleep_cnt + 8'd1;
                    end
`endif
                end
                S_ENTER: state <= S_ACTIVE;
                S_ACTIVE: begin
                    if (instr_valid && is_rfi) begin
                        pc_target <= saved_pc;
                        state     <= S_EXIT;
                    end
                end
                S_EXIT:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign stall            = state == S_SLEEP;
    assign pc_redirect      = (state == S_ENTER) || (state == S_EXIT);
    assign interrupt_active = state == S_ACTIVE;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_ack
        assign irq_ack[g] = (state == S_ENTER) && (active_id == ID_WIDTH'(g));
    end

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed + randomized bench for irq_sequencer against a cycle-level behavioural reference model.
module tb_irq_sequencer;

    localparam int TO = 5;
    localparam bit [4:0] NOP = 5'h00, WFI = 5'h1C, RFI = 5'h1E;

    logic       mem_clock, reset_bar;
    logic [4:0] opcode;
    logic       instr_valid;
    logic [7:0] pc_current;
    logic [3:0] irq_req, irq_mask;
    logic       stall, pc_redirect, interrupt_active;
    logic [7:0] pc_target, saved_pc;
    logic [3:0] irq_ack;
    logic [1:0] active_id;

    int checks = 0, failures = 0;

`ifdef IRQ_SEQ_WFI_TIMEOUT_EN
    irq_sequencer #(.WFI_TIMEOUT(TO)) dut (
        .mem_clock(mem_clock), .reset_bar(reset_bar), .opcode(opcode),
        .instr_valid(instr_valid), .pc_current(pc_current), .irq_req(irq_req),
        .irq_mask(irq_mask), .stall(stall), .pc_redirect(pc_redirect),
        .pc_target(pc_target), .irq_ack(irq_ack), .interrupt_active(interrupt_active),
        .active_id(active_id), .saved_pc(saved_pc)
    );
`else
    irq_sequencer dut (
        .mem_clock(mem_clock), .reset_bar(reset_bar), .opcode(opcode),
        .instr_valid(instr_valid), .pc_current(pc_current), .irq_req(irq_req),
        .irq_mask(irq_mask), .stall(stall), .pc_redirect(pc_redirect),
        .pc_target(pc_target), .irq_ack(irq_ack), .interrupt_active(interrupt_active),
        .active_id(active_id), .saved_pc(saved_pc)
    );
`endif

    initial mem_clock = 1'b0;
    always #5 mem_clock = ~mem_clock;

    // Reference model: sleeping / in-handler flags plus one-shot redirect events.
    bit m_sleep, m_hand, m_enter, m_exit;
    int m_id, m_saved, m_target, m_slept;

    task automatic model_reset();
        m_sleep = 0; m_hand = 0; m_enter = 0; m_exit = 0;
        m_id = 0; m_saved = 0; m_target = 0; m_slept = 0;
    endtask

    task automatic model_enter(input int w);
        m_id = w;
        m_target = (240 + 4 * w) % 256;
        m_enter = 1;
    endtask

    task automatic model_step(input bit v, input bit [4:0] op, input bit [7:0] pc,
                              input bit [3:0] req, input bit [3:0] msk);
        bit [3:0] p;
        int w;
        p = req & ~msk;
        w = -1;
        for (int i = 0; i < 4; i++) if (p[i] && w < 0) w = i;
        if (m_enter) begin
            m_enter = 0; m_hand = 1;
        end else if (m_exit) begin
            m_exit = 0;
        end else if (m_hand) begin
            if (v && op[4:1] == 4'hF) begin m_hand = 0; m_exit = 1; m_target = m_saved; end
        end else if (m_sleep) begin
            if (w >= 0) begin m_sleep = 0; model_enter(w); end
`ifdef IRQ_SEQ_WFI_TIMEOUT_EN
            else begin
                m_slept++;
                if (m_slept == TO) begin m_sleep = 0; m_exit = 1; m_target = m_saved; end
            end
`endif
        end else if (v && w >= 0) begin
            m_saved = pc; model_enter(w);
        end else if (v && op[4:1] == 4'hE) begin
            m_saved = pc; m_sleep = 1; m_slept = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("stall", 32'(stall), 32'(m_sleep));
        chk("pc_redirect", 32'(pc_redirect), 32'(m_enter | m_exit));
        chk("pc_target", 32'(pc_target), 32'(m_target));
        chk("irq_ack", 32'(irq_ack), m_enter ? (32'd1 << m_id) : 32'd0);
        chk("interrupt_active", 32'(interrupt_active), 32'(m_hand));
        chk("active_id", 32'(active_id), 32'(m_id));
        chk("saved_pc", 32'(saved_pc), 32'(m_saved));
    endtask

    task automatic cyc(input bit v, input bit [4:0] op, input bit [7:0] pc,
                       input bit [3:0] req, input bit [3:0] msk);
        @(negedge mem_clock);
        instr_valid = v; opcode = op; pc_current = pc; irq_req = req; irq_mask = msk;
        @(posedge mem_clock);
        model_step(v, op, pc, req, msk);
        #1 check_all();
    endtask

    task automatic do_reset();
        @(negedge mem_clock);
        reset_bar = 1'b0;
        model_reset();
        #1 check_all();
        repeat (2) @(posedge mem_clock);
        #1 check_all();
        @(negedge mem_clock);
        reset_bar = 1'b1;
    endtask

    initial begin
        bit v;
        bit [4:0] op;
        bit [3:0] rq, mk;
        int r;
        reset_bar = 1'b1; instr_valid = 1'b0; opcode = NOP; pc_current = '0;
        irq_req = 4'b1111; irq_mask = '0;

        // Reset with all requests held, nothing retiring
        do_reset();
        repeat (3) cyc(0, NOP, 8'h00, 4'b1111, 4'b0000);
        chk("rst_ack", 32'(irq_ack), 32'd0);

        // Entry from IDLE: line 1 wins over line 2
        cyc(1, NOP, 8'h12, 4'b0110, 4'b0000);
        chk("enter_redirect", 32'(pc_redirect), 32'd1);
        chk("enter_target", 32'(pc_target), 32'hF4);
        chk("enter_ack", 32'(irq_ack), 32'b0010);
        chk("enter_saved", 32'(saved_pc), 32'h12);
        cyc(0, NOP, 8'h00, 4'b0100, 4'b0000);
        chk("active_on", 32'(interrupt_active), 32'd1);

        // Return, then line 2 re-enters after one retired instruction
        cyc(1, RFI, 8'h00, 4'b0100, 4'b0000);
        chk("exit_target", 32'(pc_target), 32'h12);
        chk("exit_active", 32'(interrupt_active), 32'd0);
        cyc(1, NOP, 8'h13, 4'b0100, 4'b0000);
        cyc(1, NOP, 8'h13, 4'b0100, 4'b0000);
        chk("reenter_target", 32'(pc_target), 32'hF8);
        cyc(0, NOP, 8'h00, 4'b0000, 4'b0000);
        cyc(1, RFI, 8'h00, 4'b0000, 4'b0000);
        cyc(0, NOP, 8'h00, 4'b0000, 4'b0000);

        // wfi, long sleep, wake on line 3
        cyc(1, WFI, 8'h30, 4'b0000, 4'b0000);
        repeat (10) cyc(1, NOP, 8'h31, 4'b0000, 4'b0000);
`ifndef IRQ_SEQ_WFI_TIMEOUT_EN
        chk("sleep_stall", 32'(stall), 32'd1);
`endif
        cyc(0, NOP, 8'h31, 4'b1000, 4'b0000);
`ifndef IRQ_SEQ_WFI_TIMEOUT_EN
        chk("wake_target", 32'(pc_target), 32'hFC);
        chk("wake_ack", 32'(irq_ack), 32'b1000);
`endif
        cyc(0, NOP, 8'h00, 4'b0000, 4'b0000);
        cyc(1, RFI, 8'h00, 4'b0000, 4'b0000);
`ifndef IRQ_SEQ_WFI_TIMEOUT_EN
        chk("wfi_return", 32'(pc_target), 32'h30);
`endif
        cyc(0, NOP, 8'h00, 4'b0000, 4'b0000);

        // Masked request must not wake; unmasking does
        cyc(1, WFI, 8'h60, 4'b0000, 4'b0000);
        repeat (3) cyc(0, NOP, 8'h00, 4'b0001, 4'b0001);
        chk("masked_stall", 32'(stall), 32'd1);
        chk("masked_noredir", 32'(pc_redirect), 32'd0);
        cyc(0, NOP, 8'h00, 4'b0001, 4'b0000);
        chk("unmask_target", 32'(pc_target), 32'hF0);
        chk("unmask_ack", 32'(irq_ack), 32'b0001);
        cyc(0, NOP, 8'h00, 4'b0000, 4'b0000);
        cyc(1, RFI, 8'h00, 4'b0000, 4'b0000);
        cyc(0, NOP, 8'h00, 4'b0000, 4'b0000);

`ifdef IRQ_SEQ_WFI_TIMEOUT_EN
        // Timeout wake, then pending beats timeout on the same edge
        cyc(1, WFI, 8'h40, 4'b0000, 4'b0000);
        repeat (4) cyc(0, NOP, 8'h00, 4'b0000, 4'b0000);
        chk("to_still_sleep", 32'(stall), 32'd1);
        cyc(0, NOP, 8'h00, 4'b0000, 4'b0000);
        chk("to_redirect", 32'(pc_redirect), 32'd1);
        chk("to_target", 32'(pc_target), 32'h40);
        chk("to_ack", 32'(irq_ack), 32'd0);
        chk("to_active", 32'(interrupt_active), 32'd0);
        cyc(0, NOP, 8'h00, 4'b0000, 4'b0000);
        cyc(1, WFI, 8'h50, 4'b0000, 4'b0000);
        repeat (4) cyc(0, NOP, 8'h00, 4'b0000, 4'b0000);
        cyc(0, NOP, 8'h00, 4'b0010, 4'b0000);
        chk("to_race_target", 32'(pc_target), 32'hF4);
        chk("to_race_ack", 32'(irq_ack), 32'b0010);
        cyc(0, NOP, 8'h00, 4'b0000, 4'b0000);
        cyc(1, RFI, 8'h00, 4'b0000, 4'b0000);
        cyc(0, NOP, 8'h00, 4'b0000, 4'b0000);
`endif

        // Reset mid-handler is abandoned silently
        cyc(1, NOP, 8'h77, 4'b1000, 4'b0000);
        cyc(0, NOP, 8'h00, 4'b1000, 4'b0000);
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            v = $urandom_range(0, 3) != 0;
            r = $urandom_range(0, 7);
            op = (r == 0) ? WFI : (r < 3) ? RFI : 5'($urandom);
            if (r == 1) op[0] = 1'b1;
            rq = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            mk = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 199) == 0) do_reset();
            else cyc(v, op, 8'($urandom), rq, mk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
